mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: byte address width, all ports.
REQ-002 Parameter DATA_W, default 32: data word width, all ports.
REQ-003 Parameter TIMEOUT, default 16: maximum memory wait cycles per transaction; legal range 1..255.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 i_req  input  1  instruction-fetch read request, held until i_ack.
REQ-007 i_addr  input  ADDR_W  fetch address (PC).
REQ-008 i_rdata  output  DATA_W  fetched instruction word.
REQ-009 i_ack  output  1  one-cycle completion pulse for fetch.
REQ-010 d_req  input  1  data request from the MEM stage, held until d_ack.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_addr  input  ADDR_W  data address (ALU result).
REQ-013 d_wdata  input  DATA_W  store data.
REQ-014 d_rdata  output  DATA_W  load data.
REQ-015 d_ack  output  1  one-cycle completion pulse for data.
REQ-016 err  output  1  one-cycle pulse, coincident with the ack of a timed-out transaction.
REQ-017 mem_addr  output  ADDR_W  address to the shared memory.
REQ-018 mem_wdata  output  DATA_W  write data to the shared memory.
REQ-019 mem_read  output  1  read strobe.
REQ-020 mem_write  output  1  write strobe.
REQ-021 mem_rdata  input  DATA_W  memory read data, valid when mem_ready is high.
REQ-022 mem_ready  input  1  memory completion indication.

Function
REQ-023 FSM states: IDLE, BUSY_I, BUSY_D. IDLE moves to BUSY_I or BUSY_D on a grant; BUSY_x returns to IDLE on completion or timeout.
REQ-024 Grant is evaluated only in IDLE. With a single request, that port is granted. With both requests, the port not granted last (last_gnt) is granted.
REQ-025 A grant in cycle n drives registered mem_addr, mem_wdata, and mem_read or mem_write from cycle n+1. These outputs stay stable until the cycle after mem_ready is sampled high.
REQ-026 Strobe selection: a fetch drives mem_read; a data access with d_we=0 drives mem_read; a data access with d_we=1 drives mem_write. mem_read and mem_write are never high together.
REQ-027 When mem_ready is sampled high in BUSY_x, the next cycle returns to IDLE, pulses x_ack, and clears the strobes. For reads, the cycle also latches mem_rdata into x_rdata.
REQ-028 Minimum latency: request in cycle n, mem_ready high in n+1, ack in cycle n+2.
REQ-029 i_rdata and d_rdata hold their value until the next successful read completion on the same port. A store leaves d_rdata unchanged.
REQ-030 In the cycle a port's ack is high, IDLE ignores that port's req. This prevents double issue, and the other port may be granted in that cycle.
REQ-031 A wait counter clears on each grant and increments every BUSY cycle with mem_ready low. When it reaches TIMEOUT, the FSM returns to IDLE, pulses x_ack and err together, and leaves x_rdata unchanged.
REQ-032 A requester that drops req before ack does not abort the transaction. The ack still pulses.
REQ-033 last_gnt updates on every grant.
REQ-034 mem_ready seen in IDLE is ignored.

Reset
REQ-035 Asserting reset, at any time including mid-transaction, forces: state IDLE; all outputs 0; wait counter 0; last_gnt = I, so the first tie grants D. No ack is produced for an aborted transaction.
REQ-036 After reset deasserts, the first grant occurs no earlier than the first rising edge with reset low.

Structure
REQ-037 A shared package mem_arb_pkg holds the state enum, the port-id constants (PORT_I, PORT_D) and the TIMEOUT default.
REQ-038 One sub-module, mem_arb_timer, implements the wait counter with clear, enable and expired outputs. Arbitration and the FSM are in mem_port_arbiter.

Verification
REQ-039 Single fetch: i_req=1 with i_addr=0x40 at n, mem_ready=1 at n+1 with rdata=0x8C010004 -> mem_read=1 and mem_addr=0x40 at n+1; i_ack=1 and i_rdata=0x8C010004 at n+2.
REQ-040 Tie after reset: i_req=d_req=1 at n -> D granted first, I granted in the cycle d_ack pulses; next tie grants D again.
REQ-041 Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> mem_write=1 with those values, mem_read=0, d_ack after mem_ready, d_rdata unchanged.
REQ-042 Timeout: TIMEOUT=4, fetch with mem_ready held low -> i_ack and err pulse together 4 BUSY cycles after the grant cycle, i_rdata unchanged, FSM in IDLE.
REQ-043 Reset mid-read: reset asserted during BUSY_D -> strobes 0 immediately (asynchronous), no d_ack, first post-reset tie grants D.
REQ-044 Wait states: mem_ready low for 3 cycles then high -> mem_addr and strobe stable throughout, exactly one ack.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM state encoding, port identifiers and the default wait limit.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mem_arb_timer.sv
// Per-transaction memory wait counter. expired is asserted on the
// enabled cycle that would bring the count up to TIMEOUT.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Firing one cycle early lets the FSM leave BUSY exactly after TIMEOUT waits.
  assign expired = en && !clr && (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one shared memory
// port. Round-robin on ties, registered memory outputs, per-access timeout.
//
// Handshake: a requester raises x_req and holds it until x_ack; x_ack is a
// one-cycle pulse, and in that cycle IDLE does not consider x_req again.
// The memory completes an access by raising mem_ready while a strobe is high.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        dbg_state
);

  arb_state_e        state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              err_q, err_d;

  logic tmr_clr, tmr_en, tmr_expired;
  logic i_elig, d_elig, pick_d;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // A port whose ack is high this cycle is still holding req; skip it.
  assign i_elig = i_req && !i_ack_q;
  assign d_elig = d_req && !d_ack_q;
  assign pick_d = d_elig && (!i_elig || (last_gnt_q == PORT_I));

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_elig || d_elig) begin
          tmr_clr = 1'b1;
          if (pick_d) begin
            state_d     = ST_BUSY_D;
            last_gnt_d  = PORT_D;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_read_d  = !d_we;
            mem_write_d = d_we;
          end else begin
            state_d     = ST_BUSY_I;
            last_gnt_d  = PORT_I;
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
          end
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (mem_ready) begin
          state_d     = ST_IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (state_q == ST_BUSY_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (mem_read_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end else begin
          tmr_en = 1'b1;
          if (tmr_expired) begin
            state_d     = ST_IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            err_d       = 1'b1;
            i_ack_d     = (state_q == ST_BUSY_I);
            d_ack_d     = (state_q == ST_BUSY_D);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_gnt_q  <= PORT_I;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected completions
// {port, err, rdata} into a queue that an ack monitor pops and compares.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = DW + 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_we, mem_ready;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          i_ack, d_ack, err, mem_read, mem_write;
  logic [1:0]    dbg_state;

  logic [EW-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ack     (i_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic push(input logic port, input logic e, input logic [DW-1:0] data);
    exp_q.push_back({port, e, data});
  endtask

  task automatic chk_strobe(input string name, input logic [AW-1:0] addr,
                            input logic rd, input logic wr, input arb_state_e st);
    chk({name, "_addr"}, 64'(mem_addr), 64'(addr));
    chk({name, "_rw"}, 64'({mem_read, mem_write}), 64'({rd, wr}));
    chk({name, "_state"}, 64'(dbg_state), 64'(st));
  endtask

  // Monitor / scoreboard
  always @(negedge clock) begin
    logic [EW-1:0] exp_w, act_w;
    if (!reset) begin
      if (i_ack || d_ack) begin
        chk("single_ack", 64'(i_ack && d_ack), 64'd0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ack: i_ack=%0b d_ack=%0b with empty queue", i_ack, d_ack);
        end else begin
          exp_w = exp_q.pop_front();
          act_w = {d_ack, err, d_ack ? d_rdata : i_rdata};
          chk("ack_resp", 64'(act_w), 64'(exp_w));
        end
      end else if (err) begin
        tests++;
        fails++;
        $display("FAIL err_without_ack: err=1 ack=0 expected err=0");
      end
    end
  end

  // Driver
  initial begin
    reset = 1'b1;
    i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    repeat (3) step();
    chk("reset_outs", 64'({i_ack, d_ack, err, mem_read, mem_write, dbg_state}), 64'd0);
    chk("reset_data", 64'({i_rdata, d_rdata}), 64'd0);
    chk("reset_addr", 64'({mem_addr, mem_wdata}), 64'd0);
    reset = 1'b0;

    // mem_ready in IDLE is ignored
    mem_ready = 1; mem_rdata = 32'h55555555;
    repeat (2) step();
    chk("idle_ready_ignored", 64'(dbg_state), 64'(ST_IDLE));
    mem_ready = 0;

    // Single fetch, minimum latency
    i_req = 1; i_addr = 32'h40;
    push(PORT_I, 0, 32'h8C010004);
    step();
    chk_strobe("fetch", 32'h40, 1, 0, ST_BUSY_I);
    mem_ready = 1; mem_rdata = 32'h8C010004;
    step();
    chk("fetch_ack_now", 64'(i_ack), 64'd1);
    mem_ready = 0;
    step();
    chk("fetch_no_reissue", 64'({dbg_state, mem_read}), 64'({2'(ST_IDLE), 1'b0}));
    i_req = 0;
    step();

    // Tie: last grant was I, so D wins; I is granted in the d_ack cycle
    i_req = 1; i_addr = 32'h44;
    d_req = 1; d_we = 0; d_addr = 32'h200;
    push(PORT_D, 0, 32'h11111111);
    push(PORT_I, 0, 32'h22222222);
    step();
    chk_strobe("tie1_d", 32'h200, 1, 0, ST_BUSY_D);
    mem_ready = 1; mem_rdata = 32'h11111111;
    step();
    mem_ready = 0;
    step();
    chk_strobe("tie1_i", 32'h44, 1, 0, ST_BUSY_I);
    d_req = 0;
    mem_ready = 1; mem_rdata = 32'h22222222;
    step();
    mem_ready = 0;
    step();
    i_req = 0;
    step();
    // Next tie goes to D again
    i_req = 1; d_req = 1; d_addr = 32'h204;
    push(PORT_D, 0, 32'h33333333);
    step();
    chk_strobe("tie2_d", 32'h204, 1, 0, ST_BUSY_D);
    i_req = 0;
    mem_ready = 1; mem_rdata = 32'h33333333;
    step();
    mem_ready = 0;
    step();
    d_req = 0;
    step();

    // Store leaves d_rdata alone
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    push(PORT_D, 0, 32'h33333333);
    step();
    chk_strobe("store", 32'h100, 0, 1, ST_BUSY_D);
    chk("store_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    mem_ready = 1; mem_rdata = 32'hBAD0BAD0;
    step();
    mem_ready = 0;
    step();
    d_req = 0; d_we = 0;
    chk("store_done", 64'({dbg_state, mem_write}), 64'({2'(ST_IDLE), 1'b0}));

    // Three wait states; requester drops req early, transaction still completes
    i_req = 1; i_addr = 32'h80;
    push(PORT_I, 0, 32'h0A0B0C0D);
    step();
    i_req = 0;
    for (int k = 0; k < 3; k++) begin
      chk_strobe("wait", 32'h80, 1, 0, ST_BUSY_I);
      step();
    end
    chk_strobe("wait_last", 32'h80, 1, 0, ST_BUSY_I);
    mem_ready = 1; mem_rdata = 32'h0A0B0C0D;
    step();
    mem_ready = 0;
    repeat (2) step();

    // Timeout with TIMEOUT=4: four waiting BUSY cycles, then ack+err
    i_req = 1; i_addr = 32'hC0; mem_rdata = 32'hFFFFFFFF;
    push(PORT_I, 1, 32'h0A0B0C0D);
    step();
    for (int k = 0; k < 4; k++) begin
      chk_strobe("to_busy", 32'hC0, 1, 0, ST_BUSY_I);
      step();
    end
    chk("to_ack_err", 64'({i_ack, err}), 64'b11);
    chk("to_idle", 64'({dbg_state, mem_read}), 64'({2'(ST_IDLE), 1'b0}));
    step();
    i_req = 0;
    step();

    // Reset in the middle of a load
    d_req = 1; d_we = 0; d_addr = 32'h300;
    step();
    chk_strobe("rst_pre", 32'h300, 1, 0, ST_BUSY_D);
    #2 reset = 1'b1;
    #1;
    chk("rst_async", 64'({mem_read, mem_write, mem_addr, dbg_state}), 64'd0);
    chk("rst_rdata", 64'({i_rdata, d_rdata}), 64'd0);
    i_req = 1; i_addr = 32'h48;
    step();
    chk("rst_no_grant", 64'(dbg_state), 64'(ST_IDLE));
    reset = 1'b0;
    push(PORT_D, 0, 32'h77777777);
    push(PORT_I, 0, 32'h88888888);
    step();
    chk_strobe("rst_tie_d", 32'h300, 1, 0, ST_BUSY_D);
    mem_ready = 1; mem_rdata = 32'h77777777;
    step();
    mem_ready = 0;
    step();
    d_req = 0;
    chk_strobe("rst_then_i", 32'h48, 1, 0, ST_BUSY_I);
    mem_ready = 1; mem_rdata = 32'h88888888;
    step();
    mem_ready = 0;
    step();
    i_req = 0;
    repeat (3) step();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
